// File: rtl/data_ram_param_if.sv
// data_ram_param_if: CPU-side bus of the parametrised data RAM.
// master drives requests, slave returns read data and status.
interface data_ram_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] acc;
  logic              mem_read;
  logic              mem_write;
  logic              clear;
  logic              par_flip;
  logic [DATA_W-1:0] data;
  logic              rd_valid;
  logic              init_busy;
  logic              parity_err;

  modport master (
    output address, acc, mem_read, mem_write, clear, par_flip,
    input  data, rd_valid, init_busy, parity_err
  );

  modport slave (
    input  address, acc, mem_read, mem_write, clear, par_flip,
    output data, rd_valid, init_busy, parity_err
  );
endinterface

// File: rtl/data_ram_param.sv
// data_ram_param: single-port data RAM, 1-cycle reads, init sweep FSM.
// Optional stored parity per word when DATA_RAM_PARITY_EN is defined.
module data_ram_param #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int INIT_COUNT = 10
) (
  input logic clk,
  input logic rst_n,
  data_ram_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, READY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              in_init;
  logic              wr_fire;
  logic              rd_fire;
  logic              fwd;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] init_word;
  logic [DATA_W-1:0] rd_word;
  logic              perr_d;
  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;
  logic              perr_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign in_init   = (state_q == INIT);
  assign init_word = (32'(ptr_q) < 32'(INIT_COUNT))
                   ? DATA_W'(ptr_q) : '0;

  assign wr_fire = !in_init && !bus.clear && bus.mem_write;
  assign rd_fire = !in_init && !bus.clear && bus.mem_read;
  assign fwd     = wr_fire && rd_fire;

  assign we = in_init || wr_fire;
  assign wa = in_init ? ptr_q : bus.address;
  assign wd = in_init ? init_word : bus.acc;

  assign rd_word = fwd ? bus.acc : mem[bus.address];

  // Next state: sweep one word per cycle, clear restarts the sweep
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      INIT: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        if (bus.clear) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // State register and sweep pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array; contents are rebuilt by the sweep, never reset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

`ifdef DATA_RAM_PARITY_EN
  logic mem_p [DEPTH];
  logic wp;

  assign wp = in_init ? ^init_word : (^bus.acc ^ bus.par_flip);

  // Parity bit array, written alongside the data word
  always_ff @(posedge clk) begin
    if (we) mem_p[wa] <= wp;
  end

  assign perr_d = !rd_fire ? 1'b0
                : fwd ? bus.par_flip
                : (mem_p[bus.address] != ^mem[bus.address]);
`else
  logic unused_par_flip;

  assign unused_par_flip = bus.par_flip;
  assign perr_d          = 1'b0;
`endif

  // Registered read port; data holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      perr_q     <= perr_d;
      if (rd_fire) data_q <= rd_word;
    end
  end

  assign bus.data       = data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.parity_err = perr_q;
  assign bus.init_busy  = in_init;
endmodule

// File: tb/tb_data_ram_param.sv
// tb_data_ram_param: vector table plus scoreboard for data_ram_param.
// Parity expectations follow DATA_RAM_PARITY_EN.
module tb_data_ram_param;
`ifdef DATA_RAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic       wr;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] acc;
    logic       flip;
    logic [7:0] exp_d;
    logic       exp_p;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[$];

  data_ram_param_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  data_ram_param #(
    .DATA_W(8), .ADDR_W(4), .INIT_COUNT(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic wr, logic rd, logic [3:0] a,
                              logic [7:0] acc, logic fl,
                              logic [7:0] ed, logic ep);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.acc = acc;
    v.flip = fl; v.exp_d = ed; v.exp_p = ep;
    return v;
  endfunction

  // Scoreboard: every rd_valid must match the oldest expected read
  always @(negedge clk) begin
    if (bus.rd_valid) begin
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        chk("rd_valid_unexpected", 32'(bus.rd_valid), 32'd0);
      end else begin
        chk("rd_data", 32'(bus.data), 32'(sb[0].d));
        chk("parity_err", 32'(bus.parity_err), 32'(sb[0].p));
        void'(sb.pop_front());
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      chk("rd_valid_missing", 32'(bus.rd_valid), 32'd1);
      void'(sb.pop_front());
    end
  end

  task automatic idle();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.clear     = 1'b0;
    bus.par_flip  = 1'b0;
  endtask

  task automatic rd(logic [3:0] a, logic [7:0] d);
    exp_t e;
    bus.address  = a;
    bus.mem_read = 1'b1;
    e.cyc = cyc + 1; e.d = d; e.p = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    idle();
  endtask

  task automatic count_busy(string name);
    int n = 0;
    while (bus.init_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'd16);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.address = '0;
    bus.acc     = '0;
    idle();

    for (int i = 0; i < 16; i++) begin
      vecs.push_back(mk(0, 1, 4'(i), 8'h00, 0,
                        (i < 10) ? 8'(i) : 8'h00, 0));
    end
    vecs.push_back(mk(1, 0, 4'd3, 8'hA5, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'd3, 8'h00, 0, 8'hA5, 0));
    vecs.push_back(mk(0, 1, 4'd4, 8'h00, 0, 8'h04, 0));
    vecs.push_back(mk(1, 1, 4'd7, 8'h3C, 0, 8'h3C, 0));
    vecs.push_back(mk(0, 1, 4'd7, 8'h00, 0, 8'h3C, 0));
    vecs.push_back(mk(1, 0, 4'd9, 8'h01, 1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'd9, 8'h00, 0, 8'h01, PAR));
    vecs.push_back(mk(1, 0, 4'd9, 8'h01, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'd9, 8'h00, 0, 8'h01, 0));
    vecs.push_back(mk(1, 1, 4'd10, 8'h80, 1, 8'h80, PAR));
    vecs.push_back(mk(0, 1, 4'd10, 8'h00, 0, 8'h80, PAR));

    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_init_busy", 32'(bus.init_busy), 32'd1);
    chk("rst_parity_err", 32'(bus.parity_err), 32'd0);

    rst_n = 1'b1;
    count_busy("init_sweep_len");

    foreach (vecs[i]) begin
      bus.address   = vecs[i].addr;
      bus.acc       = vecs[i].acc;
      bus.mem_write = vecs[i].wr;
      bus.mem_read  = vecs[i].rd;
      bus.par_flip  = vecs[i].flip;
      if (vecs[i].rd) begin
        exp_t e;
        e.cyc = cyc + 1; e.d = vecs[i].exp_d; e.p = vecs[i].exp_p;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
    chk("data_hold", 32'(bus.data), 32'h80);
    chk("hold_rd_valid", 32'(bus.rd_valid), 32'd0);

    bus.address = 4'd2; bus.acc = 8'hFF; bus.mem_write = 1'b1;
    @(negedge clk);
    bus.address = 4'd2; bus.acc = 8'h77;
    bus.mem_write = 1'b1; bus.mem_read = 1'b1; bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    bus.address = 4'd5; bus.acc = 8'hEE;
    bus.mem_write = 1'b1; bus.mem_read = 1'b1;
    count_busy("clear_sweep_len");
    idle();
    rd(4'd2, 8'h02);
    rd(4'd5, 8'h05);
    rd(4'd3, 8'h03);
    rd(4'd9, 8'h09);
    @(negedge clk);
    chk("pre_reset_data", 32'(bus.data), 32'h09);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    bus.address = 4'd1; bus.mem_read = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midsweep_rst_busy", 32'(bus.init_busy), 32'd1);
    chk("midsweep_rst_data", 32'(bus.data), 32'd0);
    chk("midsweep_rst_valid", 32'(bus.rd_valid), 32'd0);
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_busy("resweep_len");
    rd(4'd0, 8'h00);
    rd(4'd9, 8'h09);
    rd(4'd15, 8'h00);
    rd(4'd3, 8'h03);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
